inst_queue: RTL and testbench

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue.sv | 119 +++++++++++
 tb/tb_inst_queue.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: circular buffer with multi-lane
// enqueue/dequeue, a combinational dequeue view and delay-slot tracking.
module inst_queue #(
  parameter int ENTRY_NUM = 8,
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 2,
  parameter int GHR_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [$clog2(IN_WIDTH+1)-1:0]   push_num,
  input  logic [IN_WIDTH*32-1:0]          push_pc,
  input  logic [IN_WIDTH*32-1:0]          push_inst,
  input  logic [IN_WIDTH-1:0]             push_taken,
  input  logic [IN_WIDTH*GHR_WIDTH-1:0]   push_pht,
  output logic                            can_push,
  input  logic [$clog2(OUT_WIDTH+1)-1:0]  pop_req,
  input  logic [OUT_WIDTH-1:0]            is_next_delayslot,
  output logic [OUT_WIDTH-1:0]            out_valid,
  output logic [OUT_WIDTH*32-1:0]         out_pc,
  output logic [OUT_WIDTH*32-1:0]         out_inst,
  output logic [OUT_WIDTH-1:0]            out_taken,
  output logic [OUT_WIDTH*GHR_WIDTH-1:0]  out_pht,
  output logic [OUT_WIDTH-1:0]            out_delayslot,
  output logic [$clog2(ENTRY_NUM+1)-1:0]  count
);

  localparam int PTR_W  = $clog2(ENTRY_NUM);
  localparam int CNT_W  = $clog2(ENTRY_NUM + 1);
  localparam int PUSH_W = $clog2(IN_WIDTH + 1);
  localparam int POP_W  = $clog2(OUT_WIDTH + 1);

  typedef struct packed {
    logic [31:0]          pc;
    logic [31:0]          inst;
    logic                 taken;
    logic [GHR_WIDTH-1:0] pht;
  } entry_t;

  entry_t           mem [ENTRY_NUM];
  entry_t           rd_entry;
  logic [PTR_W-1:0] head, tail;
  logic             ds_pending, ds_next;
  logic [CNT_W-1:0] push_cnt, pop_lim, pop_cnt;

  // Occupancy comes from the registered count only, so a same-cycle pop never
  // opens room for a push.
  assign can_push = (count <= CNT_W'(ENTRY_NUM - IN_WIDTH));

  // NOTE: every variable gets a default before any conditional assignment so no latch is inferred.
  always_comb begin
    push_cnt = '0;
    if (can_push)
      push_cnt = (push_num > PUSH_W'(IN_WIDTH)) ? CNT_W'(IN_WIDTH) : CNT_W'(push_num);
    pop_lim = (pop_req > POP_W'(OUT_WIDTH)) ? CNT_W'(OUT_WIDTH) : CNT_W'(pop_req);
    pop_cnt = (pop_lim < count) ? pop_lim : count;
    ds_next = ds_pending;
    for (int i = 0; i < OUT_WIDTH; i++)
      if (pop_cnt == CNT_W'(i + 1)) ds_next = is_next_delayslot[i];
  end

  // NOTE: storage is deliberately not reset; count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (rst && !flush) begin
      for (int i = 0; i < IN_WIDTH; i++)
        if (CNT_W'(i) < push_cnt)
          mem[tail + PTR_W'(i)] <= '{pc:    push_pc[i*32 +: 32],
                                     inst:  push_inst[i*32 +: 32],
                                     taken: push_taken[i],
                                     pht:   push_pht[i*GHR_WIDTH +: GHR_WIDTH]};
    end
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      ds_pending <= 1'b0;
    end else if (flush) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      ds_pending <= 1'b0;
    end else begin
      head       <= head + PTR_W'(pop_cnt);
      tail       <= tail + PTR_W'(push_cnt);
      count      <= count + push_cnt - pop_cnt;
      ds_pending <= ds_next;
    end
  end

  // Dequeue view: lane i shows entry head+i; lanes beyond count read as zero.
  always_comb begin
    out_valid     = '0;
    out_pc        = '0;
    out_inst      = '0;
    out_taken     = '0;
    out_pht       = '0;
    out_delayslot = '0;
    rd_entry      = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      if (CNT_W'(i) < count) begin
        rd_entry                         = mem[head + PTR_W'(i)];
        out_valid[i]                     = 1'b1;
        out_pc[i*32 +: 32]               = rd_entry.pc;
        out_inst[i*32 +: 32]             = rd_entry.inst;
        out_taken[i]                     = rd_entry.taken;
        out_pht[i*GHR_WIDTH +: GHR_WIDTH] = rd_entry.pht;
      end
    end
    out_delayslot[0] = ds_pending & out_valid[0];
    for (int i = 1; i < OUT_WIDTH; i++)
      out_delayslot[i] = is_next_delayslot[i-1] & out_valid[i];
  end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_inst_queue;

  localparam int ENTRY_NUM = 8;
  localparam int IN_WIDTH  = 2;
  localparam int OUT_WIDTH = 2;
  localparam int GHR_WIDTH = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [1:0]  push_num;
  logic [63:0] push_pc, push_inst;
  logic [1:0]  push_taken;
  logic [9:0]  push_pht;
  logic        can_push;
  logic [1:0]  pop_req;
  logic [1:0]  is_next_delayslot;
  logic [1:0]  out_valid;
  logic [63:0] out_pc, out_inst;
  logic [1:0]  out_taken;
  logic [9:0]  out_pht;
  logic [1:0]  out_delayslot;
  logic [3:0]  count;

  inst_queue #(
    .ENTRY_NUM(ENTRY_NUM), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .GHR_WIDTH(GHR_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .push_num(push_num),
    .push_pc(push_pc), .push_inst(push_inst), .push_taken(push_taken), .push_pht(push_pht),
    .can_push(can_push), .pop_req(pop_req), .is_next_delayslot(is_next_delayslot),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_taken(out_taken),
    .out_pht(out_pht), .out_delayslot(out_delayslot), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        taken;
    logic [4:0]  pht;
  } ent_t;

  ent_t        mq[$];
  logic        m_ds;
  logic [31:0] pc_base;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model given the inputs currently applied.
  task automatic check_model();
    int          sz;
    logic [1:0]  e_valid, e_taken, e_ds;
    logic [63:0] e_pc, e_inst;
    logic [9:0]  e_pht;
    sz = mq.size();
    e_valid = '0; e_taken = '0; e_ds = '0; e_pc = '0; e_inst = '0; e_pht = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      if (i < sz) begin
        e_valid[i]        = 1'b1;
        e_pc[i*32 +: 32]   = mq[i].pc;
        e_inst[i*32 +: 32] = mq[i].inst;
        e_taken[i]        = mq[i].taken;
        e_pht[i*5 +: 5]    = mq[i].pht;
        e_ds[i]           = (i == 0) ? m_ds : is_next_delayslot[i-1];
      end
    end
    check("count", 64'(count), 64'(sz));
    check("can_push", 64'(can_push), 64'(sz <= ENTRY_NUM - IN_WIDTH));
    check("out_valid", 64'(out_valid), 64'(e_valid));
    check("out_pc", out_pc, e_pc);
    check("out_inst", out_inst, e_inst);
    check("out_taken", 64'(out_taken), 64'(e_taken));
    check("out_pht", 64'(out_pht), 64'(e_pht));
    check("out_delayslot", 64'(out_delayslot), 64'(e_ds));
  endtask

  // Reference behaviour for one clock edge, from the queue's rules.
  task automatic model_edge();
    int n;
    bit room;
    ent_t e;
    if (!rst || flush) begin
      mq.delete();
      m_ds = 1'b0;
    end else begin
      room = (mq.size() <= ENTRY_NUM - IN_WIDTH);
      n = (int'(pop_req) < mq.size()) ? int'(pop_req) : mq.size();
      for (int i = 0; i < n; i++) void'(mq.pop_front());
      if (n > 0) m_ds = is_next_delayslot[n-1];
      if (room)
        for (int i = 0; i < int'(push_num); i++) begin
          e.pc    = push_pc[i*32 +: 32];
          e.inst  = push_inst[i*32 +: 32];
          e.taken = push_taken[i];
          e.pht   = push_pht[i*5 +: 5];
          mq.push_back(e);
        end
    end
  endtask

  // One cycle: drive at posedge+1, check at negedge, advance model at posedge, settle.
  task automatic step(input logic fl, input int pn, input int pr, input logic [1:0] ds);
    flush             = fl;
    push_num          = 2'(pn);
    pop_req           = 2'(pr);
    is_next_delayslot = ds;
    push_pc           = {pc_base + 32'd4, pc_base};
    push_inst         = {$urandom, $urandom};
    push_taken        = 2'($urandom_range(0, 3));
    push_pht          = 10'($urandom_range(0, 1023));
    pc_base           = pc_base + 32'd8;
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_pc;
    m_ds = 1'b0;
    pc_base = 32'hBFC0_0000;
    rst = 1'b0; flush = 1'b0; push_num = '0; pop_req = '0; is_next_delayslot = '0;
    push_pc = '0; push_inst = '0; push_taken = '0; push_pht = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_can_push", 64'(can_push), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pc", out_pc, 64'd0);
    check("rst_out_delayslot", 64'(out_delayslot), 64'd0);

    // First push becomes visible the next cycle
    step(0, 2, 0, 2'b00);
    check("first_count", 64'(count), 64'd2);
    check("first_valid", 64'(out_valid), 64'b11);
    check("first_pc", out_pc, 64'hBFC0_0004_BFC0_0000);
    check("first_ds", 64'(out_delayslot), 64'd0);

    // Fill to full; the push at count 8 is dropped
    step(0, 2, 0, 2'b00);
    check("fill_count4", 64'(count), 64'd4);
    step(0, 2, 0, 2'b00);
    check("fill_count6", 64'(count), 64'd6);
    check("fill_can_push6", 64'(can_push), 64'd1);
    step(0, 2, 0, 2'b00);
    check("fill_count8", 64'(count), 64'd8);
    check("fill_can_push8", 64'(can_push), 64'd0);
    step(0, 2, 0, 2'b00);
    check("full_drop_count", 64'(count), 64'd8);

    // Pop request above count with simultaneous push
    step(1, 0, 0, 2'b00);
    step(0, 1, 0, 2'b00);
    check("one_count", 64'(count), 64'd1);
    step(0, 2, 2, 2'b00);
    exp_pc = pc_base - 32'd8;
    check("under_count", 64'(count), 64'd2);
    check("under_pc0", 64'(out_pc[31:0]), 64'(exp_pc));

    // Delay-slot flag on lane 1, then pending across an empty queue
    step(0, 0, 0, 2'b01);
    check("ds_lane1", 64'(out_delayslot), 64'b10);
    step(0, 0, 1, 2'b00);
    step(0, 0, 1, 2'b01);
    check("ds_empty_count", 64'(count), 64'd0);
    check("ds_empty_masked", 64'(out_delayslot), 64'd0);
    step(0, 1, 0, 2'b00);
    check("ds_pending_lane0", 64'(out_delayslot), 64'b01);

    // Wrap-around with steady push/pop of 2
    step(1, 0, 0, 2'b00);
    step(0, 2, 2, 2'b00);
    check("wrap_first_count", 64'(count), 64'd2);
    for (int i = 0; i < 10; i++) begin
      step(0, 2, 2, 2'b00);
      check("wrap_count", 64'(count), 64'd2);
    end

    // Flush with pending delay slot and a same-cycle push
    step(0, 2, 1, 2'b01);
    step(0, 2, 0, 2'b00);
    check("pre_flush_count", 64'(count), 64'd5);
    check("pre_flush_ds", 64'(out_delayslot), 64'b01);
    step(1, 2, 0, 2'b00);
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    step(0, 1, 0, 2'b00);
    check("post_flush_count", 64'(count), 64'd1);
    check("post_flush_ds", 64'(out_delayslot), 64'd0);

    // Reset mid-operation overrides push and pop
    step(0, 2, 0, 2'b00);
    rst = 1'b0;
    step(0, 2, 1, 2'b11);
    rst = 1'b1;
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_can_push", 64'(can_push), 64'd1);
    check("midrst_valid", 64'(out_valid), 64'd0);

    // Random traffic: push-biased, then pop-biased
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 59) != 0);
      if (i < 150)
        step($urandom_range(0, 24) == 0, $urandom_range(0, 2), $urandom_range(0, 1), 2'($urandom_range(0, 3)));
      else
        step($urandom_range(0, 24) == 0, $urandom_range(0, 1), $urandom_range(0, 2), 2'($urandom_range(0, 3)));
    end
    rst = 1'b1;
    step(0, 0, 0, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
